store_stage_queue: RTL
======================

Name: store_stage_queue

Overview:
Parametrised successor to the single-entry store front-end. It buffers up to DEPTH issued stores and aligns their data. Translation is performed in order at the queue head, so a TLB miss does not back-pressure issue until the queue fills. Translated stores are forwarded to the store buffer over a valid/ready handshake, with a writeback to the issue stage. Sits between issue stage, DTLB/MMU and store_buffer inside the LSU.

Parameters:
XLEN, 64, data width in bits (32 or 64)
VLEN, 64, virtual address width
PLEN, 56, physical address width (PLEN <= VLEN)
DEPTH, 4, staging entries; power of two, >= 2
TRANS_ID_BITS, 3, transaction id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  drop all staged stores
st_valid_i  in  1  issue offers a store
st_ready_o  out  1  queue can accept (not full)
st_vaddr_i  in  VLEN  store virtual address
st_data_i  in  XLEN  unaligned store data
st_be_i  in  XLEN/8  byte enables (already aligned)
st_size_i  in  2  transfer size
st_trans_id_i  in  TRANS_ID_BITS  scoreboard id
translation_req_o  out  1  head requests translation
translation_vaddr_o  out  VLEN  head vaddr
dtlb_hit_i  in  1  translation valid this cycle
paddr_i  in  PLEN  translated address
ex_valid_i  in  1  translation/access exception for head
sb_valid_o  out  1  store offered to store buffer
sb_ready_i  in  1  store buffer accepts
sb_paddr_o  out  PLEN  physical address
sb_data_o  out  XLEN  aligned data
sb_be_o  out  XLEN/8  byte enables
sb_size_o  out  2  transfer size
wb_valid_o  out  1  writeback pulse
wb_trans_id_o  out  TRANS_ID_BITS  writeback id
wb_ex_o  out  1  writeback carries exception
count_o  out  $clog2(DEPTH)+1  occupied entries
empty_o  out  1  count_o == 0

Behaviour:
- Reset: queue empty, pointers 0, FSM IDLE. All outputs 0 except st_ready_o=1, empty_o=1.
- Storage: circular FIFO; rd/wr pointers wrap modulo DEPTH; count saturates at DEPTH.
- Enqueue on st_valid_i && st_ready_o; st_ready_o = (count < DEPTH). No full-bypass: a simultaneous pop does not raise ready in the same cycle.
- Align at enqueue: data rotated left by 8*vaddr[log2(XLEN/8)-1:0] bits; be stored unchanged.
- Head FSM:
  - IDLE: queue empty. Go to XLATE the cycle after the queue becomes non-empty; no same-cycle bypass.
  - XLATE: translation_req_o=1, translation_vaddr_o=head vaddr.
    - ex_valid_i (priority over hit): wb_valid_o=1, wb_ex_o=1, pop head; go to XLATE if entries remain, else IDLE.
    - dtlb_hit_i: register paddr_i into head entry, go to PUSH.
    - Neither: hold in XLATE.
  - PUSH: sb_valid_o=1 with head paddr/data/be/size; outputs held stable until accepted.
    - sb_ready_i: pop, wb_valid_o=1, wb_ex_o=0, wb_trans_id_o=head id; go to XLATE if count after pop > 0, else IDLE.
- Latency, empty queue: enqueue cycle 0, translation_req_o cycle 1. Hit at cycle 1 gives sb_valid_o at cycle 2, then wb in the handshake cycle.
- Writeback order equals issue order; at most one wb per cycle.
- Flush:
  - Next cycle: queue empty, FSM IDLE.
  - Same cycle: sb_valid_o, wb_valid_o and translation_req_o are forced 0; a concurrent enqueue is discarded.
- count_o reflects registered state; push+pop in the same cycle leaves it unchanged.

Optional Feature:
STORE_STAGE_MMU_EN
- Defined: translation path as above.
- Undefined:
  - translation_req_o tied 0; dtlb_hit_i/paddr_i/ex_valid_i ignored.
  - XLATE is skipped: IDLE/pop transitions go straight to PUSH with sb_paddr_o = head vaddr[PLEN-1:0].
  - Enqueue-to-sb_valid_o latency becomes 1 cycle.

Test Plan:
- XLEN=64: enqueue vaddr 0x1003, data 0xAB, be 0x08, id 2; hit at cycle 1 with paddr 0x8000_1003; sb_ready_i=1 -> cycle 2: sb_valid_o=1, sb_data_o=0x00000000AB000000, sb_paddr_o=0x80001003, wb_valid_o=1, wb_trans_id_o=2, wb_ex_o=0.
- TLB miss 5 cycles with 4 more stores offered -> queue accepts 3 more, then st_ready_o=0 at count_o=4. After the hit, stores drain in order; st_ready_o returns 1 the cycle after the first pop.
- ex_valid_i on head id 5 -> wb_valid_o=1, wb_ex_o=1, id 5, no sb_valid_o; next entry enters XLATE the following cycle.
- sb_ready_i low 3 cycles in PUSH -> sb_* stable for all 3 cycles; wb only on the accept cycle.
- flush_i with 3 entries and a concurrent enqueue -> next cycle count_o=0, empty_o=1, no wb/sb pulses; later stores function normally (pointer wrap checked over 2*DEPTH stores).
- STORE_STAGE_MMU_EN undefined: enqueue vaddr 0x40 -> sb_valid_o next cycle with sb_paddr_o=0x40, translation_req_o never asserted.

Source files
------------

// File: rtl/store_stage_queue.sv
// store_stage_queue: DEPTH-entry store staging FIFO between issue, DTLB and
// the store buffer. Data is rotated into lane position on enqueue. The head
// entry is translated in order, then handed to the store buffer over a
// valid/ready handshake. Each head pop produces one writeback pulse.
// Optional build macro: STORE_STAGE_MMU_EN. When it is defined, the head is
// translated through the DTLB. When it is undefined, the virtual address is
// used directly as the physical address.
module store_stage_queue #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 64,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     st_valid_i,
    output logic                     st_ready_o,
    input  logic [VLEN-1:0]          st_vaddr_i,
    input  logic [XLEN-1:0]          st_data_i,
    input  logic [XLEN/8-1:0]        st_be_i,
    input  logic [1:0]               st_size_i,
    input  logic [TRANS_ID_BITS-1:0] st_trans_id_i,
    output logic                     translation_req_o,
    output logic [VLEN-1:0]          translation_vaddr_o,
    input  logic                     dtlb_hit_i,
    input  logic [PLEN-1:0]          paddr_i,
    input  logic                     ex_valid_i,
    output logic                     sb_valid_o,
    input  logic                     sb_ready_i,
    output logic [PLEN-1:0]          sb_paddr_o,
    output logic [XLEN-1:0]          sb_data_o,
    output logic [XLEN/8-1:0]        sb_be_o,
    output logic [1:0]               sb_size_o,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     wb_ex_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int unsigned BEW  = XLEN / 8;
    localparam int unsigned OFFW = $clog2(BEW);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;

    typedef struct packed {
        logic [VLEN-1:0]          vaddr;
        logic [XLEN-1:0]          data;
        logic [BEW-1:0]           be;
        logic [1:0]               size;
        logic [TRANS_ID_BITS-1:0] id;
    } entry_t;

    typedef enum logic [1:0] {IDLE, XLATE, PUSH} state_e;

`ifdef STORE_STAGE_MMU_EN
    localparam state_e FIRST_ST = XLATE;
`else
    localparam state_e FIRST_ST = PUSH;
`endif

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PLEN-1:0] head_paddr;
    logic [PTRW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNTW-1:0] count_q, count_next;
    state_e          state_q;

    logic            push, pop, more;
    logic            xlate_ex, xlate_hit, sb_fire;
    logic [OFFW+2:0] shamt;
    logic [XLEN-1:0] aligned;

    // Rotate store data left by the byte offset so each byte sits in its lane
    assign shamt   = {st_vaddr_i[OFFW-1:0], 3'b000};
    assign aligned = (st_data_i << shamt) | (st_data_i >> (XLEN - 32'(shamt)));

    assign head       = mem[rd_ptr_q];
    assign st_ready_o = count_q < CNTW'(DEPTH);
    assign empty_o    = count_q == '0;
    assign count_o    = count_q;
    assign push       = st_valid_i && st_ready_o && !flush_i;

`ifdef STORE_STAGE_MMU_EN
    logic [PLEN-1:0] paddr_mem [DEPTH];

    assign translation_req_o = (state_q == XLATE) && !flush_i;
    assign head_paddr        = paddr_mem[rd_ptr_q];

    // Capture the translated address into the head slot on a clean hit
    always_ff @(posedge clk_i) begin
        if (xlate_hit) paddr_mem[rd_ptr_q] <= paddr_i;
    end
`else
    logic unused_mmu;

    assign unused_mmu        = ^{dtlb_hit_i, paddr_i, ex_valid_i};
    assign translation_req_o = 1'b0;
    assign head_paddr        = head.vaddr[PLEN-1:0];
`endif

    // Exception takes priority over a hit; both only count while requesting
    assign xlate_ex   = translation_req_o && ex_valid_i;
    assign xlate_hit  = translation_req_o && !ex_valid_i && dtlb_hit_i;
    assign sb_valid_o = (state_q == PUSH) && !flush_i;
    assign sb_fire    = sb_valid_o && sb_ready_i;
    assign pop        = xlate_ex || sb_fire;
    assign count_next = count_q + CNTW'(push) - CNTW'(pop);
    assign more       = count_next != '0;

    assign translation_vaddr_o = translation_req_o ? head.vaddr : '0;
    assign sb_paddr_o          = sb_valid_o ? head_paddr : '0;
    assign sb_data_o           = sb_valid_o ? head.data  : '0;
    assign sb_be_o             = sb_valid_o ? head.be    : '0;
    assign sb_size_o           = sb_valid_o ? head.size  : '0;
    assign wb_valid_o          = pop;
    assign wb_ex_o             = xlate_ex;
    assign wb_trans_id_o       = pop ? head.id : '0;

    // Entry payload write; storage contents need no reset
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= '{vaddr: st_vaddr_i, data: aligned, be: st_be_i,
                                     size: st_size_i, id: st_trans_id_i};
    end

    // Circular FIFO pointers and occupancy; flush empties the queue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
            count_q <= count_next;
        end
    end

    // Head FSM: wait for an entry, translate it, then offer it to the store buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:  if (push) state_q <= FIRST_ST;
                XLATE: begin
                    if (xlate_ex)       state_q <= more ? XLATE : IDLE;
                    else if (xlate_hit) state_q <= PUSH;
                end
                PUSH:  if (sb_fire) state_q <= more ? FIRST_ST : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
